time_set_unit: RTL and testbench

- Parametrised successor of the watch time-setting block: holds sec/min/hour/ap registers and edits them from inc/dec buttons.
- Adds a seconds field, a field-select bus and a selectable 12h/24h mode.
- Adds free-running advance from a 1 Hz tick with carry chain, and optional auto-repeat for held buttons.
- Sits between the debounced button inputs and the display/alarm compare logic.

---
 rtl/time_pkg.sv | 34 +++
 rtl/btn_repeat.sv | 106 ++++++++++
 rtl/time_set_unit.sv | 111 +++++++++++
 tb/tb_time_set_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/time_pkg.sv
// Shared constants, field-select encodings and repeat-FSM states for the time-setting block.
package time_pkg;

  localparam int FIELD_W = 7;

  localparam logic [FIELD_W-1:0] SEC_MAX     = 7'd59;
  localparam logic [FIELD_W-1:0] MIN_MAX     = 7'd59;
  localparam logic [FIELD_W-1:0] HOUR_MAX_12 = 7'd11;
  localparam logic [FIELD_W-1:0] HOUR_MAX_24 = 7'd23;

  localparam logic [1:0] SEL_SEC  = 2'd0;
  localparam logic [1:0] SEL_MIN  = 2'd1;
  localparam logic [1:0] SEL_HOUR = 2'd2;
  localparam logic [1:0] SEL_AP   = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } rpt_state_e;

  // One edit step inside a single field: wraps at either end, never carries.
  function automatic logic [FIELD_W-1:0] wrap_step(
    input logic [FIELD_W-1:0] val,
    input logic [FIELD_W-1:0] max,
    input logic               up
  );
    if (up) begin
      return (val >= max) ? '0 : val + FIELD_W'(1);
    end
    return (val == '0) ? max : val - FIELD_W'(1);
  endfunction

endpackage

// File: rtl/btn_repeat.sv
// Press detection for the inc/dec buttons plus optional hold-to-repeat FSM.
// Auto-repeat is built only when AUTO_REPEAT_EN is defined.
module btn_repeat
  import time_pkg::*;
#(
  parameter int HOLD_CYC = 50,
  parameter int RPT_CYC  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       edit,
  input  logic [1:0] sel,
  input  logic       inc,
  input  logic       dec,
  output logic       inc_act,
  output logic       dec_act
);

  logic inc_q, dec_q;
  logic inc_arm, dec_arm;
  logic inc_press, dec_press;
  logic rpt_inc, rpt_dec;

  // A button held through reset stays disarmed until it has been seen released.
  assign inc_press = edit & inc & ~dec & ~inc_q & inc_arm;
  assign dec_press = edit & dec & ~inc & ~dec_q & dec_arm;

  always_ff @(posedge clk) begin
    if (!rst) begin
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      inc_arm <= 1'b0;
      dec_arm <= 1'b0;
      inc_act <= 1'b0;
      dec_act <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling the pre-edge values.
      inc_q   <= inc;
      dec_q   <= dec;
      inc_arm <= inc_arm | ~inc;
      dec_arm <= dec_arm | ~dec;
      inc_act <= inc_press | rpt_inc;
      dec_act <= dec_press | rpt_dec;
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int CNT_W = $clog2(HOLD_CYC > RPT_CYC ? HOLD_CYC : RPT_CYC);

  rpt_state_e       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic             dir, dir_d;
  logic [1:0]       sel_q;
  logic             held;
  logic             abort;

  assign held  = dir ? dec : inc;
  assign abort = ~held | (inc & dec) | ~edit | (sel != sel_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      dir   <= 1'b0;
      sel_q <= SEL_SEC;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      dir   <= dir_d;
      sel_q <= sel;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    state_d = state;
    cnt_d   = cnt;
    dir_d   = dir;
    rpt_inc = 1'b0;
    rpt_dec = 1'b0;
    if (state == IDLE || abort) begin
      // A fresh press of the other button can restart the hold in the same cycle.
      state_d = IDLE;
      if (inc_press || dec_press) begin
        state_d = HOLD;
        cnt_d   = CNT_W'(HOLD_CYC - 1);
        dir_d   = dec_press;
      end
    end else if (cnt == '0) begin
      state_d = REPEAT;
      cnt_d   = CNT_W'(RPT_CYC - 1);
      rpt_inc = ~dir;
      rpt_dec = dir;
    end else begin
      cnt_d = cnt - CNT_W'(1);
    end
  end
`else
  logic unused_cfg;

  assign rpt_inc    = 1'b0;
  assign rpt_dec    = 1'b0;
  assign unused_cfg = (^sel) ^ (HOLD_CYC > RPT_CYC);
`endif

endmodule

// File: rtl/time_set_unit.sv
// Watch time register block: 1 Hz running advance with full carry chain, and
// per-field inc/dec editing. Define AUTO_REPEAT_EN to enable held-button auto-repeat.
module time_set_unit
  import time_pkg::*;
#(
  parameter bit HOUR_24  = 1'b0,
  parameter int HOLD_CYC = 50,
  parameter int RPT_CYC  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               edit,
  input  logic [1:0]         sel,
  input  logic               inc,
  input  logic               dec,
  output logic [FIELD_W-1:0] sec,
  output logic [FIELD_W-1:0] min,
  output logic [FIELD_W-1:0] hour,
  output logic               ap,
  output logic               adj
);

  localparam logic [FIELD_W-1:0] HOUR_MAX = HOUR_24 ? HOUR_MAX_24 : HOUR_MAX_12;

  logic               inc_act, dec_act;
  logic [FIELD_W-1:0] sec_d, min_d, hour_d;
  logic               ap_d, adj_d;

  btn_repeat #(
    .HOLD_CYC(HOLD_CYC),
    .RPT_CYC (RPT_CYC)
  ) u_btn (
    .clk    (clk),
    .rst    (rst),
    .edit   (edit),
    .sel    (sel),
    .inc    (inc),
    .dec    (dec),
    .inc_act(inc_act),
    .dec_act(dec_act)
  );

  always_comb begin
    sec_d  = sec;
    min_d  = min;
    hour_d = hour;
    ap_d   = ap;
    adj_d  = 1'b0;
    if (edit) begin
      // edit and sel are taken from the cycle the action strobe is presented.
      if (inc_act || dec_act) begin
        case (sel)
          SEL_SEC: begin
            sec_d = wrap_step(sec, SEC_MAX, inc_act);
            adj_d = 1'b1;
          end
          SEL_MIN: begin
            min_d = wrap_step(min, MIN_MAX, inc_act);
            adj_d = 1'b1;
          end
          SEL_HOUR: begin
            hour_d = wrap_step(hour, HOUR_MAX, inc_act);
            adj_d  = 1'b1;
          end
          SEL_AP: begin
            if (!HOUR_24) begin
              ap_d  = ~ap;
              adj_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end else if (tick) begin
      if (sec == SEC_MAX) begin
        sec_d = '0;
        if (min == MIN_MAX) begin
          min_d = '0;
          if (hour == HOUR_MAX) begin
            hour_d = '0;
            if (!HOUR_24) ap_d = ~ap;
          end else begin
            hour_d = hour + FIELD_W'(1);
          end
        end else begin
          min_d = min + FIELD_W'(1);
        end
      end else begin
        sec_d = sec + FIELD_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sec  <= '0;
      min  <= '0;
      hour <= '0;
      ap   <= 1'b0;
      adj  <= 1'b0;
    end else begin
      sec  <= sec_d;
      min  <= min_d;
      hour <= hour_d;
      ap   <= ap_d;
      adj  <= adj_d;
    end
  end

endmodule

// File: tb/tb_time_set_unit.sv
// Scoreboard bench for time_set_unit: a 12h and a 24h instance share directed stimulus;
// expectations are queued with a due cycle and checked by an independent monitor.
module tb_time_set_unit;

  logic       clk  = 1'b0;
  logic       rst  = 1'b0;
  logic       tick = 1'b0;
  logic       edit = 1'b0;
  logic [1:0] sel  = 2'd0;
  logic       inc  = 1'b0;
  logic       dec  = 1'b0;

  logic [6:0] sec12, min12, hour12, sec24, min24, hour24;
  logic       ap12, adj12, ap24, adj24;

  time_set_unit #(.HOUR_24(1'b0), .HOLD_CYC(50), .RPT_CYC(10)) u12 (
    .clk(clk), .rst(rst), .tick(tick), .edit(edit), .sel(sel), .inc(inc), .dec(dec),
    .sec(sec12), .min(min12), .hour(hour12), .ap(ap12), .adj(adj12)
  );

  time_set_unit #(.HOUR_24(1'b1), .HOLD_CYC(50), .RPT_CYC(10)) u24 (
    .clk(clk), .rst(rst), .tick(tick), .edit(edit), .sel(sel), .inc(inc), .dec(dec),
    .sec(sec24), .min(min24), .hour(hour24), .ap(ap24), .adj(adj24)
  );

  always #5 clk = ~clk;

`ifdef AUTO_REPEAT_EN
  localparam int HOLD_SEC   = 4;
  localparam int ADJ_TOT_12 = 14;
  localparam int ADJ_TOT_24 = 13;
`else
  localparam int HOLD_SEC   = 1;
  localparam int ADJ_TOT_12 = 10;
  localparam int ADJ_TOT_24 = 9;
`endif

  typedef struct {
    int    due;
    bit    dut;
    string name;
    int    s;
    int    m;
    int    h;
    bit    a;
    bit    j;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_chk    = 0;
  int   n_pass   = 0;
  int   adj_cnt12 = 0;
  int   adj_cnt24 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops every expectation that has come due and compares against the DUT.
  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [22:0] got, want;
    if (adj12 === 1'b1) adj_cnt12++;
    if (adj24 === 1'b1) adj_cnt24++;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e    = sb.pop_front();
      got  = e.dut ? {sec24, min24, hour24, ap24, adj24} : {sec12, min12, hour12, ap12, adj12};
      want = {7'(e.s), 7'(e.m), 7'(e.h), e.a, e.j};
      n_chk++;
      if (e.due == cyc && got === want) begin
        n_pass++;
      end else begin
        $display("FAIL %s (%s) cyc %0d: got sec=%0d min=%0d hour=%0d ap=%b adj=%b, want sec=%0d min=%0d hour=%0d ap=%b adj=%b",
                 e.name, e.dut ? "24h" : "12h", cyc, got[22:16], got[15:9], got[8:2], got[1], got[0],
                 e.s, e.m, e.h, e.a, e.j);
      end
    end
  end

  task automatic expect1(input int dly, input bit d, input string nm,
                         input int s, input int m, input int h, input bit a, input bit j);
    exp_t e;
    e.due = cyc + dly; e.dut = d; e.name = nm;
    e.s = s; e.m = m; e.h = h; e.a = a; e.j = j;
    sb.push_back(e);
  endtask

  task automatic expect2(input int dly, input string nm,
                         input int s, input int m, input int h, input bit a, input bit j);
    expect1(dly, 1'b0, nm, s, m, h, a, j);
    expect1(dly, 1'b1, nm, s, m, h, a, j);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle button pulse; the field updates two edges after the press is driven.
  task automatic press(input bit use_dec);
    if (use_dec) dec = 1'b1;
    else inc = 1'b1;
    step(1);
    inc = 1'b0;
    dec = 1'b0;
    step(3);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(1);
  endtask

  initial begin
    expect2(2, "reset", 0, 0, 0, 1'b0, 1'b0);
    expect2(3, "reset_hold", 0, 0, 0, 1'b0, 1'b0);
    step(3);
    rst = 1'b1;

    for (int i = 1; i <= 60; i++) begin
      expect2(1, "tick_run", i % 60, i / 60, 0, 1'b0, 1'b0);
      pulse_tick();
    end

    edit = 1'b1;
    sel  = 2'd0;
    expect2(2, "sec_dec_wrap", 59, 1, 0, 1'b0, 1'b1);
    expect2(3, "sec_adj_once", 59, 1, 0, 1'b0, 1'b0);
    press(1'b1);
    sel = 2'd1;
    expect2(2, "min_dec", 59, 0, 0, 1'b0, 1'b1);
    expect2(3, "min_adj_once", 59, 0, 0, 1'b0, 1'b0);
    press(1'b1);
    expect2(2, "min_dec_wrap", 59, 59, 0, 1'b0, 1'b1);
    expect2(3, "min_wrap_adj_once", 59, 59, 0, 1'b0, 1'b0);
    press(1'b1);
    sel = 2'd2;
    expect1(2, 1'b0, "hour_dec_wrap", 59, 59, 11, 1'b0, 1'b1);
    expect1(2, 1'b1, "hour_dec_wrap", 59, 59, 23, 1'b0, 1'b1);
    expect1(3, 1'b0, "hour_adj_once", 59, 59, 11, 1'b0, 1'b0);
    expect1(3, 1'b1, "hour_adj_once", 59, 59, 23, 1'b0, 1'b0);
    press(1'b1);

    edit = 1'b0;
    expect1(1, 1'b0, "full_rollover", 0, 0, 0, 1'b1, 1'b0);
    expect1(1, 1'b1, "full_rollover", 0, 0, 0, 1'b0, 1'b0);
    pulse_tick();

    edit = 1'b1;
    sel  = 2'd3;
    expect1(2, 1'b0, "ap_toggle", 0, 0, 0, 1'b0, 1'b1);
    expect1(2, 1'b1, "ap_ignored", 0, 0, 0, 1'b0, 1'b0);
    expect2(3, "ap_after", 0, 0, 0, 1'b0, 1'b0);
    press(1'b0);
    sel = 2'd2;
    expect1(2, 1'b0, "hour_dec_from_0", 0, 0, 11, 1'b0, 1'b1);
    expect1(2, 1'b1, "hour_dec_from_0", 0, 0, 23, 1'b0, 1'b1);
    expect1(3, 1'b0, "hour_dec_after", 0, 0, 11, 1'b0, 1'b0);
    expect1(3, 1'b1, "hour_dec_after", 0, 0, 23, 1'b0, 1'b0);
    press(1'b1);
    expect2(2, "hour_inc_wrap", 0, 0, 0, 1'b0, 1'b1);
    expect2(3, "hour_inc_after", 0, 0, 0, 1'b0, 1'b0);
    press(1'b0);

    sel = 2'd0;
    inc = 1'b1;
    expect2(2, "hold_press", 1, 0, 0, 1'b0, 1'b1);
    expect2(3, "hold_press_after", 1, 0, 0, 1'b0, 1'b0);
`ifdef AUTO_REPEAT_EN
    expect2(52, "hold_first_repeat", 2, 0, 0, 1'b0, 1'b1);
    expect2(62, "hold_repeat_2", 3, 0, 0, 1'b0, 1'b1);
    expect2(72, "hold_repeat_3", 4, 0, 0, 1'b0, 1'b1);
`else
    expect2(52, "hold_no_repeat", 1, 0, 0, 1'b0, 1'b0);
`endif
    step(80);
    inc = 1'b0;
    expect2(4, "hold_final", HOLD_SEC, 0, 0, 1'b0, 1'b0);
    step(6);

    inc  = 1'b1;
    dec  = 1'b1;
    tick = 1'b1;
    expect2(3, "both_high_tick", HOLD_SEC, 0, 0, 1'b0, 1'b0);
    step(1);
    tick = 1'b0;
    step(3);
    dec = 1'b0;
    expect2(4, "no_press_after_both", HOLD_SEC, 0, 0, 1'b0, 1'b0);
    step(5);
    inc  = 1'b0;
    edit = 1'b0;
    expect2(3, "tick_lost", HOLD_SEC, 0, 0, 1'b0, 1'b0);
    step(4);
    expect2(1, "tick_resumes", HOLD_SEC + 1, 0, 0, 1'b0, 1'b0);
    pulse_tick();

    edit = 1'b1;
    inc  = 1'b1;
    expect2(2, "pre_reset_press", HOLD_SEC + 2, 0, 0, 1'b0, 1'b1);
`ifdef AUTO_REPEAT_EN
    expect2(52, "pre_reset_repeat", HOLD_SEC + 3, 0, 0, 1'b0, 1'b1);
`endif
    step(55);
    rst = 1'b0;
    expect2(1, "reset_mid_hold", 0, 0, 0, 1'b0, 1'b0);
    step(1);
    rst = 1'b1;
    expect2(20, "held_after_reset", 0, 0, 0, 1'b0, 1'b0);
    expect2(60, "held_after_reset_long", 0, 0, 0, 1'b0, 1'b0);
    step(62);
    inc = 1'b0;
    step(2);
    expect2(2, "repress_after_reset", 1, 0, 0, 1'b0, 1'b1);
    expect2(3, "repress_after", 1, 0, 0, 1'b0, 1'b0);
    press(1'b0);

    step(3);
    n_chk++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
    n_chk++;
    if (adj_cnt12 == ADJ_TOT_12) n_pass++;
    else $display("FAIL adj_total_12h: got %0d pulses, want %0d", adj_cnt12, ADJ_TOT_12);
    n_chk++;
    if (adj_cnt24 == ADJ_TOT_24) n_pass++;
    else $display("FAIL adj_total_24h: got %0d pulses, want %0d", adj_cnt24, ADJ_TOT_24);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
